// File: rtl/execute_cycle_if.sv
// E-stage bundle: decoded instruction fields entering execute and the E/M
// register contents leaving it, plus the combinational branch/stall results.
interface execute_cycle_if;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic        ALUSrcE;
    logic        FlushE;
    logic [2:0]  ALUControlE;
    logic [18:0] RD1_E;
    logic [18:0] RD2_E;
    logic [18:0] Imm_Ext_E;
    logic [18:0] ResultW;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [18:0] WriteDataM;
    logic [18:0] ALU_ResultM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, ResultW,
               ForwardA_E, ForwardB_E, RD_E, PCE, PCPlus4E,
        input  RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
               WriteDataM, ALU_ResultM, PCSrcE, PCTargetE, StallE
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, FlushE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, ResultW,
               ForwardA_E, ForwardB_E, RD_E, PCE, PCPlus4E,
        output RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
               WriteDataM, ALU_ResultM, PCSrcE, PCTargetE, StallE
    );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: forwarding muxes, 19-bit ALU, beq resolution and E/M register.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier for opcode 111.
module execute_cycle (
    input logic            clk,
    input logic            rst,
    execute_cycle_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    alu_op_t     op;
    logic [18:0] src_a;
    logic [18:0] fwd_b;
    logic [18:0] src_b;
    logic [18:0] sub_out;
    logic [18:0] alu_out;
    logic        zero;

    logic        load_bubble;
    logic        load_mul;
    logic [18:0] mul_result;
    logic [18:0] mul_wdata;
    logic        stall;

    logic        regwrite_q, memwrite_q, resultsrc_q;
    logic [4:0]  rd_q;
    logic [31:0] pcplus4_q;
    logic [18:0] wdata_q, alu_result_q;

    logic        regwrite_d, memwrite_d, resultsrc_d;
    logic [4:0]  rd_d;
    logic [31:0] pcplus4_d;
    logic [18:0] wdata_d, alu_result_d;

    assign op = alu_op_t'(bus.ALUControlE);

    always_comb begin
        case (bus.ForwardA_E)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = bus.RD1_E;
        endcase
        case (bus.ForwardB_E)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = alu_result_q;
            default: fwd_b = bus.RD2_E;
        endcase
        src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    end

    assign sub_out = src_a - src_b;
    assign zero    = (sub_out == '0);

    always_comb begin
        alu_out = '0;
        case (op)
            OP_ADD:  alu_out = src_a + src_b;
            OP_SUB:  alu_out = sub_out;
            OP_AND:  alu_out = src_a & src_b;
            OP_OR:   alu_out = src_a | src_b;
            OP_XOR:  alu_out = src_a ^ src_b;
            OP_SLT:  alu_out = {18'b0, $signed(src_a) < $signed(src_b)};
            OP_SLL:  alu_out = (src_b[4:0] >= 5'd19) ? '0 : (src_a << src_b[4:0]);
            default: alu_out = '0;
        endcase
    end

    assign bus.PCSrcE    = bus.BranchE & zero;
    assign bus.PCTargetE = bus.PCE + {{13{bus.Imm_Ext_E[18]}}, bus.Imm_Ext_E};

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t  state, state_next;
    logic        is_mul;
    logic        accept;
    logic        step;
    logic [18:0] mul_a, mul_b, acc, wdata_hold;
    logic [4:0]  count;

    assign is_mul = (op == OP_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins in every state: it drops back to IDLE and the bubble default stands.
    always_comb begin
        state_next  = state;
        load_bubble = bus.FlushE;
        load_mul    = 1'b0;
        stall       = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.FlushE && is_mul) begin
                    accept      = 1'b1;
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                if (bus.FlushE) begin
                    state_next = IDLE;
                end else begin
                    step        = 1'b1;
                    stall       = 1'b1;
                    load_bubble = 1'b1;
                    if (count == 5'd18) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                if (!bus.FlushE) begin
                    load_mul = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            acc        <= '0;
            count      <= '0;
            wdata_hold <= '0;
        end else if (accept) begin
            mul_a      <= src_a;
            mul_b      <= src_b;
            acc        <= '0;
            count      <= '0;
            wdata_hold <= fwd_b;
        end else if (step) begin
            if (mul_b[0]) begin
                acc <= acc + mul_a;
            end
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            count <= count + 5'd1;
        end
    end

    assign mul_result = acc;
    assign mul_wdata  = wdata_hold;
`else
    assign load_bubble = bus.FlushE;
    assign load_mul    = 1'b0;
    assign mul_result  = '0;
    assign mul_wdata   = '0;
    assign stall       = 1'b0;
`endif

    assign bus.StallE = stall & rst;

    always_comb begin
        regwrite_d   = bus.RegWriteE;
        memwrite_d   = bus.MemWriteE;
        resultsrc_d  = bus.ResultSrcE;
        rd_d         = bus.RD_E;
        pcplus4_d    = bus.PCPlus4E;
        wdata_d      = fwd_b;
        alu_result_d = alu_out;
        if (load_bubble) begin
            regwrite_d   = 1'b0;
            memwrite_d   = 1'b0;
            resultsrc_d  = 1'b0;
            rd_d         = '0;
            pcplus4_d    = '0;
            wdata_d      = '0;
            alu_result_d = '0;
        end else if (load_mul) begin
            wdata_d      = mul_wdata;
            alu_result_d = mul_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            resultsrc_q  <= 1'b0;
            rd_q         <= '0;
            pcplus4_q    <= '0;
            wdata_q      <= '0;
            alu_result_q <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            memwrite_q   <= memwrite_d;
            resultsrc_q  <= resultsrc_d;
            rd_q         <= rd_d;
            pcplus4_q    <= pcplus4_d;
            wdata_q      <= wdata_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign bus.RegWriteM   = regwrite_q;
    assign bus.MemWriteM   = memwrite_q;
    assign bus.ResultSrcM  = resultsrc_q;
    assign bus.RD_M        = rd_q;
    assign bus.PCPlus4M    = pcplus4_q;
    assign bus.WriteDataM  = wdata_q;
    assign bus.ALU_ResultM = alu_result_q;
endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle against an arithmetic reference model.
// Multiplier scenarios are built when EXEC_MUL_EN is defined.
module tb_execute_cycle;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic        exp_rw, exp_mw, exp_rs;
  logic [4:0]  exp_rd;
  logic [31:0] exp_pc4;
  logic [18:0] exp_wd, exp_alu;

`ifdef EXEC_MUL_EN
  localparam int MAX_OP = 6;
`else
  localparam int MAX_OP = 7;
`endif

  execute_cycle_if bus();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [77:0] got_m();
    return {bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M,
            bus.PCPlus4M, bus.WriteDataM, bus.ALU_ResultM};
  endfunction

  function automatic logic [77:0] want_m();
    return {exp_rw, exp_mw, exp_rs, exp_rd, exp_pc4, exp_wd, exp_alu};
  endfunction

  function automatic int sval(input logic [18:0] v);
    return v[18] ? int'(v) - 524288 : int'(v);
  endfunction

  function automatic logic [18:0] ref_alu(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0: return 19'(int'(a) + int'(b));
      3'd1: return 19'(int'(a) - int'(b));
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sval(a) < sval(b)) ? 19'd1 : 19'd0;
      3'd6: return (int'(sh) >= 19) ? 19'd0 : 19'(longint'(a) * (longint'(1) << sh));
`ifdef EXEC_MUL_EN
      default: return 19'(longint'(a) * longint'(b));
`else
      default: return 19'd0;
`endif
    endcase
  endfunction

  function automatic logic [18:0] ref_fwd(input logic [1:0] sel, input logic [18:0] reg_val);
    if (sel == 2'b01) return bus.ResultW;
    if (sel == 2'b10) return exp_alu;
    return reg_val;
  endfunction

  task automatic model_edge();
    logic [18:0] a, fb, b;
    a  = ref_fwd(bus.ForwardA_E, bus.RD1_E);
    fb = ref_fwd(bus.ForwardB_E, bus.RD2_E);
    b  = bus.ALUSrcE ? bus.Imm_Ext_E : fb;
    if (bus.FlushE) begin
      {exp_rw, exp_mw, exp_rs, exp_rd, exp_pc4, exp_wd, exp_alu} = '0;
    end else begin
      exp_rw  = bus.RegWriteE;
      exp_mw  = bus.MemWriteE;
      exp_rs  = bus.ResultSrcE;
      exp_rd  = bus.RD_E;
      exp_pc4 = bus.PCPlus4E;
      exp_wd  = fb;
      exp_alu = ref_alu(bus.ALUControlE, a, b);
    end
  endtask

  task automatic rand_inputs(input int max_op, input bit allow_flush);
    bus.RegWriteE   = 1'($urandom);
    bus.MemWriteE   = 1'($urandom);
    bus.ResultSrcE  = 1'($urandom);
    bus.BranchE     = 1'($urandom);
    bus.ALUSrcE     = 1'($urandom);
    bus.FlushE      = allow_flush && ($urandom_range(0, 7) == 0);
    bus.ALUControlE = 3'($urandom_range(0, max_op));
    bus.RD1_E       = 19'($urandom);
    bus.RD2_E       = 19'($urandom);
    bus.Imm_Ext_E   = 19'($urandom);
    bus.ResultW     = 19'($urandom);
    bus.ForwardA_E  = 2'($urandom);
    bus.ForwardB_E  = 2'($urandom);
    bus.RD_E        = 5'($urandom);
    bus.PCE         = $urandom;
    bus.PCPlus4E    = $urandom;
    if ($urandom_range(0, 3) == 0) bus.RD2_E = bus.RD1_E;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [18:0] a, input logic [18:0] b);
    bus.RegWriteE   = 1'b1;
    bus.MemWriteE   = 1'b0;
    bus.ResultSrcE  = 1'b0;
    bus.BranchE     = 1'b0;
    bus.ALUSrcE     = 1'b0;
    bus.FlushE      = 1'b0;
    bus.ALUControlE = op;
    bus.RD1_E       = a;
    bus.RD2_E       = b;
    bus.Imm_Ext_E   = 19'($urandom);
    bus.ResultW     = 19'($urandom);
    bus.ForwardA_E  = 2'b00;
    bus.ForwardB_E  = 2'b00;
    bus.RD_E        = 5'($urandom_range(1, 31));
    bus.PCE         = $urandom;
    bus.PCPlus4E    = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(7, 1'b0);
      if (i == 1) bus.ALUControlE = 3'b111;
      @(posedge clk);
      #1;
      checks++;
      if (got_m() !== '0 || bus.StallE !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold got m=%h stall=%b want m=0 stall=0", got_m(), bus.StallE);
      end
    end
    {exp_rw, exp_mw, exp_rs, exp_rd, exp_pc4, exp_wd, exp_alu} = '0;
    @(negedge clk);
    rst = 1'b1;
    drive_op(3'b000, 19'd5, 19'd7);
    model_edge();
    @(posedge clk);
    #1;
    checks++;
    if (bus.ALU_ResultM !== 19'd12) begin
      failures++;
      $display("FAIL reset_first_add got=%0d want=12", bus.ALU_ResultM);
    end
    checks++;
    if (got_m() !== want_m()) begin
      failures++;
      $display("FAIL reset_first_m got=%h want=%h", got_m(), want_m());
    end
  endtask

  task automatic test_forwarding();
    drive_op(3'b000, 19'h8, 19'h8);
    model_edge();
    @(posedge clk);
    #1;
    drive_op(3'b001, 19'($urandom), 19'($urandom));
    bus.ForwardA_E = 2'b10;
    bus.ForwardB_E = 2'b01;
    bus.ResultW    = 19'd3;
    model_edge();
    @(posedge clk);
    #1;
    checks++;
    if (bus.ALU_ResultM !== 19'h0000D || bus.WriteDataM !== 19'd3) begin
      failures++;
      $display("FAIL forwarding got alu=%h wd=%h want alu=0000d wd=00003", bus.ALU_ResultM, bus.WriteDataM);
    end
    checks++;
    if (got_m() !== want_m()) begin
      failures++;
      $display("FAIL forwarding_m got=%h want=%h", got_m(), want_m());
    end
  endtask

  task automatic test_edge_ops();
    logic [2:0]  ops [4];
    logic [18:0] av  [4];
    logic [18:0] bv  [4];
    logic [18:0] rv  [4];
    ops = '{3'b101, 3'b110, 3'b110, 3'b000};
    av  = '{19'h40000, 19'd1, 19'd1, 19'h7FFFF};
    bv  = '{19'd1, 19'd18, 19'd19, 19'd1};
    rv  = '{19'd1, 19'h40000, 19'd0, 19'd0};
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], av[i], bv[i]);
      model_edge();
      @(posedge clk);
      #1;
      checks++;
      if (bus.ALU_ResultM !== rv[i]) begin
        failures++;
        $display("FAIL edge_op%0d got=%h want=%h", i, bus.ALU_ResultM, rv[i]);
      end
    end
  endtask

  task automatic test_branch();
    drive_op(3'b000, 19'd9, 19'd9);
    bus.BranchE   = 1'b1;
    bus.PCE       = 32'h100;
    bus.Imm_Ext_E = 19'h7FFFC;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'hFC) begin
      failures++;
      $display("FAIL branch_taken got src=%b tgt=%h want src=1 tgt=000000fc", bus.PCSrcE, bus.PCTargetE);
    end
    bus.RD2_E = 19'd8;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b0) begin
      failures++;
      $display("FAIL branch_not_taken got src=%b want src=0", bus.PCSrcE);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [18:0] a, fb, b;
    logic        want_src;
    logic [31:0] want_tgt;
    for (int i = 0; i < 60; i++) begin
      rand_inputs(MAX_OP, 1'b1);
      #1;
      a        = ref_fwd(bus.ForwardA_E, bus.RD1_E);
      fb       = ref_fwd(bus.ForwardB_E, bus.RD2_E);
      b        = bus.ALUSrcE ? bus.Imm_Ext_E : fb;
      want_src = bus.BranchE && (int'(a) == int'(b));
      want_tgt = 32'(longint'(bus.PCE) + longint'(sval(bus.Imm_Ext_E)));
      checks++;
      if ({bus.PCSrcE, bus.PCTargetE, bus.StallE} !== {want_src, want_tgt, 1'b0}) begin
        failures++;
        $display("FAIL random_comb%0d got src=%b tgt=%h stall=%b want src=%b tgt=%h stall=0",
                 i, bus.PCSrcE, bus.PCTargetE, bus.StallE, want_src, want_tgt);
      end
      model_edge();
      @(posedge clk);
      #1;
      checks++;
      if (got_m() !== want_m()) begin
        failures++;
        $display("FAIL random_m%0d op=%0d got=%h want=%h", i, bus.ALUControlE, got_m(), want_m());
      end
    end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul_case(input logic [18:0] a, input logic [18:0] b);
    int stalls;
    int dirty;
    drive_op(3'b111, 19'($urandom), b);
    bus.ResultSrcE = 1'b1;
    bus.ForwardA_E = 2'b01;
    bus.ResultW    = a;
    exp_rw  = 1'b1;
    exp_mw  = 1'b0;
    exp_rs  = 1'b1;
    exp_rd  = bus.RD_E;
    exp_pc4 = bus.PCPlus4E;
    exp_wd  = b;
    exp_alu = 19'(longint'(a) * longint'(b));
    stalls = 0;
    dirty  = 0;
    for (int c = 1; c <= 21; c++) begin
      #1;
      if (bus.StallE === 1'b1) stalls++;
      @(posedge clk);
      #1;
      if (c < 21 && got_m() !== '0) dirty++;
      if (c < 20) bus.ResultW = 19'($urandom);
    end
    checks++;
    if (stalls != 20) begin
      failures++;
      $display("FAIL mul_stall_cycles got=%0d want=20", stalls);
    end
    checks++;
    if (dirty != 0) begin
      failures++;
      $display("FAIL mul_bubbles got=%0d non-bubble edges want=0", dirty);
    end
    checks++;
    if (got_m() !== want_m()) begin
      failures++;
      $display("FAIL mul_result %h*%h got=%h want=%h", a, b, got_m(), want_m());
    end
  endtask

  task automatic test_mul();
    test_mul_case(19'd123, 19'd45);
    checks++;
    if (bus.ALU_ResultM !== 19'd5535) begin
      failures++;
      $display("FAIL mul_123x45 got=%0d want=5535", bus.ALU_ResultM);
    end
    test_mul_case(19'h7FFFF, 19'h7FFFF);
    checks++;
    if (bus.ALU_ResultM !== 19'd1) begin
      failures++;
      $display("FAIL mul_neg1sq got=%0d want=1", bus.ALU_ResultM);
    end
    test_mul_case(19'($urandom), 19'($urandom));
  endtask

  task automatic test_flush_mul();
    drive_op(3'b111, 19'd77, 19'd91);
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.StallE !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy_stall got=%b want=1", bus.StallE);
    end
    bus.FlushE = 1'b1;
    #1;
    checks++;
    if (bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall_drop got=%b want=0", bus.StallE);
    end
    @(posedge clk);
    #1;
    {exp_rw, exp_mw, exp_rs, exp_rd, exp_pc4, exp_wd, exp_alu} = '0;
    checks++;
    if (got_m() !== '0) begin
      failures++;
      $display("FAIL flush_bubble got=%h want=0", got_m());
    end
    drive_op(3'b000, 19'd2, 19'd3);
    model_edge();
    #1;
    checks++;
    if (bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL flush_add_stall got=%b want=0", bus.StallE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got_m() !== want_m() || bus.ALU_ResultM !== 19'd5) begin
      failures++;
      $display("FAIL flush_add got=%h want=%h", got_m(), want_m());
    end
  endtask

  task automatic test_reset_mid_mul();
    drive_op(3'b111, 19'd300, 19'd17);
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (got_m() !== '0 || bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_mul got m=%h stall=%b want m=0 stall=0", got_m(), bus.StallE);
    end
    {exp_rw, exp_mw, exp_rs, exp_rd, exp_pc4, exp_wd, exp_alu} = '0;
    @(negedge clk);
    rst = 1'b1;
    drive_op(3'b000, 19'd4, 19'd6);
    model_edge();
    #1;
    checks++;
    if (bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle_stall got=%b want=0", bus.StallE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got_m() !== want_m() || bus.ALU_ResultM !== 19'd10) begin
      failures++;
      $display("FAIL rst_next_add got=%h want=%h", got_m(), want_m());
    end
    test_mul_case(19'd1000, 19'd3);
  endtask
`else
  task automatic test_mul_disabled();
    drive_op(3'b111, 19'($urandom), 19'($urandom));
    model_edge();
    #1;
    checks++;
    if (bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL nomul_stall got=%b want=0", bus.StallE);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got_m() !== want_m() || bus.ALU_ResultM !== 19'd0) begin
      failures++;
      $display("FAIL nomul_result got=%h want=%h", got_m(), want_m());
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_forwarding();
    test_edge_ops();
    test_branch();
    test_random();
`ifdef EXEC_MUL_EN
    test_mul();
    test_flush_mul();
    test_reset_mid_mul();
`else
    test_mul_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
